// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with rename tags and commit bypass
module rename_regfile #(
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int NREAD   = 2,
    parameter int NCOMMIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic [NREAD*5-1:0]       rd_addr,
    output logic [NREAD-1:0]         rd_busy,
    output logic [NREAD*XLEN-1:0]    rd_val,
    output logic [NREAD*ROB_W-1:0]   rd_tag,
    input  logic                     ren_valid,
    input  logic [4:0]               ren_rd,
    input  logic [ROB_W-1:0]         ren_tag,
    input  logic [NCOMMIT-1:0]       cm_valid,
    input  logic [NCOMMIT*5-1:0]     cm_rd,
    input  logic [NCOMMIT*ROB_W-1:0] cm_tag,
    input  logic [NCOMMIT*XLEN-1:0]  cm_val,
    output logic [5:0]               busy_cnt
);

    logic [XLEN-1:0]  val_q [1:31];
    logic [ROB_W-1:0] tag_q [1:31];
    logic [31:1]      busy_q;
    logic [31:1]      clr;
    logic             ren_fire;
    logic [4:0]       ra;

    assign ren_fire = rdy && !flush && ren_valid && (ren_rd != 5'd0);

    // A commit retires the producer only if it is still the newest one for that register.
    always_comb begin
        clr = '0;
        for (int r = 1; r < 32; r++) begin
            for (int j = 0; j < NCOMMIT; j++) begin
                if (cm_valid[j] && cm_rd[j*5 +: 5] == 5'(r) &&
                    cm_tag[j*ROB_W +: ROB_W] == tag_q[r])
                    clr[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int r = 1; r < 32; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
        end else if (rdy) begin
            for (int r = 1; r < 32; r++) begin
                // Later ports are younger; the last matching assignment wins.
                for (int j = 0; j < NCOMMIT; j++) begin
                    if (cm_valid[j] && cm_rd[j*5 +: 5] == 5'(r))
                        val_q[r] <= cm_val[j*XLEN +: XLEN];
                end
                if (flush) begin
                    busy_q[r] <= 1'b0;
                end else if (ren_fire && ren_rd == 5'(r)) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= ren_tag;
                end else if (clr[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_busy = '0;
        rd_val  = '0;
        rd_tag  = '0;
        ra      = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = rd_addr[i*5 +: 5];
            if (ra != 5'd0) begin
                rd_busy[i]                = busy_q[ra];
                rd_val[i*XLEN +: XLEN]    = val_q[ra];
                rd_tag[i*ROB_W +: ROB_W]  = tag_q[ra];
                for (int j = 0; j < NCOMMIT; j++) begin
                    if (rdy && cm_valid[j] && cm_rd[j*5 +: 5] == ra && busy_q[ra] &&
                        cm_tag[j*ROB_W +: ROB_W] == tag_q[ra]) begin
                        rd_busy[i]             = 1'b0;
                        rd_val[i*XLEN +: XLEN] = cm_val[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int r = 1; r < 32; r++)
            busy_cnt = busy_cnt + 6'(busy_q[r]);
    end

endmodule
